fnd_scan_controller: RTL and testbench
======================================

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

Interface
REQ-001 Parameter: CLK_DIV, default 100000, clock cycles per digit-scan tick (legal range 2..2^20).
REQ-002 Port: i_clk  input  1  rising-edge system clock.
REQ-003 Port: i_reset  input  1  reset, synchronous, active-high.
REQ-004 Port: i_bcd  input  16  four BCD digits; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
REQ-005 Port: i_load  input  1  single-cycle request to stage i_bcd for display.
REQ-006 Port: o_load_ack  output  1  one-cycle pulse when staged data becomes the displayed value.
REQ-007 Port: o_Fnd  output  4  nibble for the active digit; feeds the BCD-to-FND font decoder.
REQ-008 Port: o_digit_sel  output  4  active-low common-anode digit enables; bit n selects digit n.
REQ-009 Port: o_frame_start  output  1  one-cycle pulse on the tick where digit 0 becomes active.

Function
REQ-010 The prescaler SHALL count 0..CLK_DIV-1 and wrap; the tick SHALL be asserted in the cycle the prescaler equals CLK_DIV-1.
REQ-011 On each tick, the digit index SHALL advance 0->1->2->3->0.
REQ-012 All outputs SHALL be registered and SHALL update in the cycle after the tick, reflecting the new index: o_digit_sel = ~(1 << idx), o_Fnd = nibble idx of the shadow register.
REQ-013 Between ticks, o_Fnd and o_digit_sel SHALL hold; at most one o_digit_sel bit SHALL be low at any time.
REQ-014 A tick advancing idx from 3 to 0 SHALL be the frame boundary; o_frame_start SHALL pulse for one cycle, aligned with the output update.
REQ-015 When i_load is sampled high, i_bcd SHALL be captured into a staging register and a pending flag set.
REQ-016 A later i_load while pending SHALL overwrite staging; only the last value is displayed and only one ack is issued.
REQ-017 At the frame boundary, if pending, staging SHALL be copied to shadow, pending cleared, and o_load_ack pulsed for one cycle, aligned with o_frame_start.
REQ-018 If i_load coincides with the boundary tick, the current i_bcd SHALL go directly to shadow, and the new digit 0 SHALL show it, with o_load_ack in the same cycle.
REQ-019 Shadow SHALL change only at frame boundaries, so no frame shows mixed old and new digits.
REQ-020 Nibbles 4'ha..4'hf SHALL pass through unmodified; the decoder handles them.

Reset
REQ-021 While i_reset is high: prescaler = 0, idx = 3, shadow = 16'hFFFF, staging = 16'hFFFF, pending = 0.
REQ-022 While i_reset is high: o_Fnd = 4'hf, o_digit_sel = 4'b1111, o_load_ack = 0, o_frame_start = 0.
REQ-023 Reset mid-operation SHALL discard any pending load without an ack.
REQ-024 The first tick after reset SHALL be a frame boundary (idx 3->0).

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: for digits 3..1, a digit SHALL output 4'hf when it and all more-significant shadow digits are 4'h0; digit 0 SHALL never be blanked.
REQ-026 Macro LEADING_ZERO_BLANK_EN undefined: o_Fnd SHALL always be the raw shadow nibble.

Verification (CLK_DIV=4)
REQ-027 Reset test: release reset at cycle 0 -> outputs stay 4'hf / 4'b1111 through cycle 3; at cycle 4, o_digit_sel=4'b1110, o_Fnd=4'hf, o_frame_start=1.
REQ-028 Load test: i_load with 16'h1234 during idx 1 -> ack at next boundary; digits 4,3,2,1 then appear with sel 1110,1101,1011,0111, each held for 4 cycles.
REQ-029 Repeated-load test: 16'h1111 then 16'h2222 in the same frame -> exactly one ack; next frame shows 2,2,2,2.
REQ-030 Boundary-coincident test: i_load with 16'h0009 in the boundary tick cycle -> o_load_ack and o_frame_start in the same cycle; digit 0 shows 4'h9.
REQ-031 Blanking test: load 16'h0050 -> with LEADING_ZERO_BLANK_EN the digits show 0,5,f,f; without it they show 0,5,0,0.
REQ-032 Reset-mid-op test: i_load 16'h7777, then i_reset before the boundary -> no ack, shadow stays 16'hFFFF, outputs blank.

Source files
------------

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed FND scan controller with double-buffered BCD display data.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is never blanked).
module fnd_scan_controller #(
   parameter int CLK_DIV = 100000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_bcd,
   input  logic        i_load,
   output logic        o_load_ack,
   output logic [3:0]  o_Fnd,
   output logic [3:0]  o_digit_sel,
   output logic        o_frame_start
);

   // state   | meaning
   // SCAN_D0 | digit 0 (rightmost) enabled
   // SCAN_D1 | digit 1 enabled
   // SCAN_D2 | digit 2 enabled
   // SCAN_D3 | digit 3 enabled; also the reset state, so the first tick is a frame boundary

   localparam int             PW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      SCAN_D0 = 2'd0,
      SCAN_D1 = 2'd1,
      SCAN_D2 = 2'd2,
      SCAN_D3 = 2'd3
   } scan_e;

   scan_e         state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [15:0]   staging_q, staging_d;
   logic [15:0]   shadow_q, shadow_d;
   logic          pending_q, pending_d;
   logic [3:0]    fnd_q, fnd_d;
   logic [3:0]    sel_q, sel_d;
   logic          ack_q, ack_d;
   logic          fs_q, fs_d;

   logic          tick;
   logic          boundary;
   logic [3:0]    nibble;
   logic [3:0]    shown;

   assign tick     = (pre_q == PRE_LAST);
   assign boundary = tick && (state_q == SCAN_D3);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= SCAN_D3;
         pre_q     <= '0;
         staging_q <= 16'hFFFF;
         shadow_q  <= 16'hFFFF;
         pending_q <= 1'b0;
         fnd_q     <= 4'hF;
         sel_q     <= 4'b1111;
         ack_q     <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         fnd_q     <= fnd_d;
         sel_q     <= sel_d;
         ack_q     <= ack_d;
         fs_q      <= fs_d;
      end
   end

   always_comb begin
      pre_d     = tick ? '0 : pre_q + 1'b1;
      state_d   = tick ? scan_e'(state_q + 2'd1) : state_q;
      staging_d = staging_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      // A load landing on the boundary tick bypasses staging so the new frame shows it at once.
      if (boundary) begin
         if (i_load) begin
            shadow_d = i_bcd;
         end else if (pending_q) begin
            shadow_d = staging_q;
         end
         pending_d = 1'b0;
      end else if (i_load) begin
         staging_d = i_bcd;
         pending_d = 1'b1;
      end
   end

   always_comb begin
      nibble = shadow_d[4*state_d +: 4];
`ifdef LEADING_ZERO_BLANK_EN
      shown = nibble;
      case (state_d)
         SCAN_D3: if (shadow_d[15:12] == 4'h0) shown = 4'hF;
         SCAN_D2: if (shadow_d[15:8] == 8'h00) shown = 4'hF;
         SCAN_D1: if (shadow_d[15:4] == 12'h000) shown = 4'hF;
         default: shown = nibble;
      endcase
`else
      shown = nibble;
`endif
   end

   always_comb begin
      fnd_d = fnd_q;
      sel_d = sel_q;
      ack_d = 1'b0;
      fs_d  = 1'b0;
      if (tick) begin
         fnd_d = shown;
         sel_d = ~(4'b0001 << state_d);
         fs_d  = boundary;
         ack_d = boundary && (i_load || pending_q);
      end
   end

   assign o_Fnd         = fnd_q;
   assign o_digit_sel   = sel_q;
   assign o_load_ack    = ack_q;
   assign o_frame_start = fs_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Randomized plus directed bench for fnd_scan_controller against a frame-level reference model.
module tb_fnd_scan_controller;

   localparam int CLK_DIV = 4;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [15:0] i_bcd;
   logic        i_load;
   logic        o_load_ack;
   logic [3:0]  o_Fnd;
   logic [3:0]  o_digit_sel;
   logic        o_frame_start;

   int checks   = 0;
   int failures = 0;

   // model: t = prescaler value at the next clock edge
   int          t;
   logic [15:0] m_shadow, m_staging;
   bit          m_pending;
   logic [3:0]  e_fnd, e_sel;
   logic        e_ack, e_fs;
   int          ack_seen;

   always #5 clk = ~clk;

   fnd_scan_controller #(.CLK_DIV(CLK_DIV)) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_bcd         (i_bcd),
      .i_load        (i_load),
      .o_load_ack    (o_load_ack),
      .o_Fnd         (o_Fnd),
      .o_digit_sel   (o_digit_sel),
      .o_frame_start (o_frame_start)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [3:0] disp(input logic [15:0] sh, input int k);
      logic [15:0] upper;
      upper = sh >> (4 * k);
`ifdef LEADING_ZERO_BLANK_EN
      if (k > 0 && upper == 16'h0) return 4'hF;
`endif
      return upper[3:0];
   endfunction

   task automatic model_edge(input logic r, input logic l, input logic [15:0] b);
      bit tick, bnd;
      int k;
      if (r) begin
         t = 0;
         m_shadow = 16'hFFFF; m_staging = 16'hFFFF; m_pending = 0;
         e_fnd = 4'hF; e_sel = 4'b1111; e_ack = 0; e_fs = 0;
      end else begin
         tick = (t % CLK_DIV) == CLK_DIV - 1;
         k    = (t / CLK_DIV) % 4;
         bnd  = tick && k == 0;
         e_ack = 0; e_fs = 0;
         if (bnd) begin
            if (l) begin
               m_shadow = b; e_ack = 1;
            end else if (m_pending) begin
               m_shadow = m_staging; e_ack = 1;
            end
            m_pending = 0;
         end else if (l) begin
            m_staging = b; m_pending = 1;
         end
         if (tick) begin
            e_sel = ~(4'b0001 << k);
            e_fnd = disp(m_shadow, k);
            e_fs  = bnd;
         end
         t++;
      end
   endtask

   task automatic cyc(input logic r, input logic l, input logic [15:0] b);
      i_reset = r; i_load = l; i_bcd = b;
      model_edge(r, l, b);
      @(posedge clk);
      @(negedge clk);
      ack_seen += int'(o_load_ack);
      chk("fnd", o_Fnd, e_fnd);
      chk("digit_sel", o_digit_sel, e_sel);
      chk("load_ack", o_load_ack, e_ack);
      chk("frame_start", o_frame_start, e_fs);
      chk("sel_onecold", 16'($countones(~o_digit_sel) <= 1), 16'd1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0);
   endtask

   // advance until the model's next-edge prescaler phase within a frame equals p
   task automatic idle_until(input int p);
      int n;
      n = 0;
      while ((t % (4 * CLK_DIV)) != p && n < 64) begin
         cyc(1'b0, 1'b0, 16'h0);
         n++;
      end
      if ((t % (4 * CLK_DIV)) != p) chk("idle_timeout", 16'd0, 16'd1);
   endtask

   initial begin
      ack_seen = 0;
      i_reset = 1'b1; i_load = 1'b0; i_bcd = 16'h0;

      // reset and first boundary
      cyc(1'b1, 1'b0, 16'h0);
      cyc(1'b1, 1'b1, 16'h5555);
      cyc(1'b1, 1'b0, 16'h0);
      idle(4);
      chk("rst_frame_start", 16'(o_frame_start), 16'd1);
      chk("rst_sel", 16'(o_digit_sel), 16'h000E);
      chk("rst_fnd", 16'(o_Fnd), 16'h000F);

      // load during digit 1
      idle_until(9);
      cyc(1'b0, 1'b1, 16'h1234);
      idle(40);

      // repeated load within one frame gives one ack
      idle_until(5);
      ack_seen = 0;
      cyc(1'b0, 1'b1, 16'h1111);
      idle(2);
      cyc(1'b0, 1'b1, 16'h2222);
      idle(20);
      chk("repeat_ack_count", 16'(ack_seen), 16'd1);

      // load coincident with the boundary tick
      idle_until(3);
      cyc(1'b0, 1'b1, 16'h0009);
      chk("coin_ack", 16'(o_load_ack), 16'd1);
      chk("coin_frame_start", 16'(o_frame_start), 16'd1);
      chk("coin_fnd", 16'(o_Fnd), 16'h0009);
      idle(20);

      // leading-zero behaviour
      idle_until(8);
      cyc(1'b0, 1'b1, 16'h0050);
      idle(40);

      // reset before the boundary discards the pending load
      idle_until(6);
      ack_seen = 0;
      cyc(1'b0, 1'b1, 16'h7777);
      idle(2);
      cyc(1'b1, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 16'h0);
      idle(40);
      chk("rstmid_ack_count", 16'(ack_seen), 16'd0);

      // random traffic
      for (int i = 0; i < 2500; i++) begin
         cyc(1'($urandom_range(0, 599) == 0),
             1'($urandom_range(0, 9) == 0),
             16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1);
   end

endmodule
